// File: rtl/fixed2float.sv
// Converts 48-bit signed fixed point to FP16 with round-to-nearest-even and saturation.
// Four register levels: |x|, normalise, denormal shift, round/pack into the output register.
module fixed2float #(
   parameter int FRAC_BITS = 24
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [47:0] fixed_in,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [15:0] float_o,
   output logic        ovf_o,
   output logic        unf_o
);

   localparam logic signed [7:0] EXP_OFS = 8'(15 - FRAC_BITS);

   logic               stall;
   logic               advance;

   logic               s1_valid_q;
   logic               s1_sign_q;
   logic [47:0]        s1_mag_q;
   logic [47:0]        s1_mag_d;

   logic               s2_valid_q;
   logic               s2_sign_q;
   logic               s2_zero_q;
   logic               s2_zero_d;
   logic [47:0]        s2_norm_q;
   logic [47:0]        s2_norm_d;
   logic signed [7:0]  s2_exp_q;
   logic signed [7:0]  s2_exp_d;
   logic [5:0]         lead_pos;

   logic               s3_valid_q;
   logic               s3_sign_q;
   logic               s3_zero_q;
   logic               s3_normal_q;
   logic               s3_normal_d;
   logic               s3_guard_q;
   logic               s3_guard_d;
   logic               s3_sticky_q;
   logic               s3_sticky_d;
   logic [10:0]        s3_sig_q;
   logic [10:0]        s3_sig_d;
   logic signed [7:0]  s3_exp_q;
   logic [3:0]         den_shift;
   logic [59:0]        den_ext;

   logic               valid_q;
   logic [15:0]        float_q;
   logic [15:0]        float_d;
   logic               ovf_q;
   logic               ovf_d;
   logic               unf_q;
   logic               unf_d;
   logic               round_up;
   logic [11:0]        sig_rnd;
   logic signed [8:0]  exp_rnd;

   assign stall   = valid_q & ~ready_i;
   assign advance = ~stall;
   assign ready_o = ~stall;

   assign valid_o = valid_q;
   assign float_o = float_q;
   assign ovf_o   = ovf_q;
   assign unf_o   = unf_q;

   // Unsigned negate: -2^47 maps onto 2^47 without overflow.
   assign s1_mag_d = fixed_in[47] ? (48'd0 - fixed_in) : fixed_in;

   always_comb begin
      lead_pos = '0;
      for (int i = 0; i < 48; i++) begin
         if (s1_mag_q[i]) lead_pos = 6'(i);
      end
   end

   assign s2_norm_d = s1_mag_q << (6'd47 - lead_pos);
   assign s2_exp_d  = $signed({2'b00, lead_pos}) + EXP_OFS;
   assign s2_zero_d = (s1_mag_q == '0);

   // Subnormals reuse the normal rounding datapath after a right shift of (1 - E);
   // beyond 12 the value is below half the smallest subnormal and rounds to zero.
   always_comb begin
      if (s2_exp_q >= 8'sd1)
         den_shift = 4'd0;
      else if (s2_exp_q <= -8'sd11)
         den_shift = 4'd12;
      else
         den_shift = 4'(8'sd1 - s2_exp_q);
   end

   assign den_ext     = {s2_norm_q, 12'd0} >> den_shift;
   assign s3_sig_d    = den_ext[59:49];
   assign s3_guard_d  = den_ext[48];
   assign s3_sticky_d = |den_ext[47:0];
   assign s3_normal_d = (s2_exp_q >= 8'sd1);

   assign round_up = s3_guard_q & (s3_sticky_q | s3_sig_q[0]);
   assign sig_rnd  = {1'b0, s3_sig_q} + {11'd0, round_up};
   assign exp_rnd  = {s3_exp_q[7], s3_exp_q} + {8'd0, sig_rnd[11]};

   always_comb begin
      float_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      if (s3_zero_q) begin
         float_d = '0;
      end else if (s3_normal_q) begin
         if (exp_rnd >= 9'sd31) begin
            float_d = {s3_sign_q, 15'h7BFF};
            ovf_d   = 1'b1;
         end else begin
            float_d = {s3_sign_q, exp_rnd[4:0], sig_rnd[9:0]};
         end
      end else if (sig_rnd[10:0] == 11'd0) begin
         float_d = {s3_sign_q, 15'h0000};
         unf_d   = 1'b1;
      end else begin
         // A carry into bit 10 lands in the exponent field as the minimum normal.
         float_d = {s3_sign_q, 4'd0, sig_rnd[10:0]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_mag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_sign_q   <= 1'b0;
         s2_zero_q   <= 1'b0;
         s2_norm_q   <= '0;
         s2_exp_q    <= '0;
         s3_valid_q  <= 1'b0;
         s3_sign_q   <= 1'b0;
         s3_zero_q   <= 1'b0;
         s3_normal_q <= 1'b0;
         s3_guard_q  <= 1'b0;
         s3_sticky_q <= 1'b0;
         s3_sig_q    <= '0;
         s3_exp_q    <= '0;
         valid_q     <= 1'b0;
         float_q     <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else if (advance) begin
         s1_valid_q  <= valid_i;
         s1_sign_q   <= fixed_in[47];
         s1_mag_q    <= s1_mag_d;
         s2_valid_q  <= s1_valid_q;
         s2_sign_q   <= s1_sign_q;
         s2_zero_q   <= s2_zero_d;
         s2_norm_q   <= s2_norm_d;
         s2_exp_q    <= s2_exp_d;
         s3_valid_q  <= s2_valid_q;
         s3_sign_q   <= s2_sign_q;
         s3_zero_q   <= s2_zero_q;
         s3_normal_q <= s3_normal_d;
         s3_guard_q  <= s3_guard_d;
         s3_sticky_q <= s3_sticky_d;
         s3_sig_q    <= s3_sig_d;
         s3_exp_q    <= s2_exp_q;
         valid_q     <= s3_valid_q;
         float_q     <= float_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

endmodule

// File: tb/tb_fixed2float.sv
// Bench for fixed2float: FRAC_BITS=24 and FRAC_BITS=26 instances share stimulus and are
// compared against an arithmetic FP16 reference model.
module tb_fixed2float;

   logic        clk;
   logic        reset_n;
   logic        valid_i;
   logic        ready_i;
   logic [47:0] fixed_in;

   logic        ready24, vo24, ovf24, unf24;
   logic [15:0] f24;
   logic        ready26, vo26, ovf26, unf26;
   logic [15:0] f26;

   int errors = 0;
   int checks = 0;

   fixed2float #(.FRAC_BITS(24)) u_dut24 (
      .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready24),
      .fixed_in(fixed_in), .valid_o(vo24), .ready_i(ready_i),
      .float_o(f24), .ovf_o(ovf24), .unf_o(unf24)
   );

   fixed2float #(.FRAC_BITS(26)) u_dut26 (
      .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready26),
      .fixed_in(fixed_in), .valid_o(vo26), .ready_i(ready_i),
      .float_o(f26), .ovf_o(ovf26), .unf_o(unf26)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: quantum = 2^(max(floor(log2 v), -14) - 10); value/quantum rounded half-to-even.
   // Returns {ovf, unf, fp16}.
   function automatic logic [17:0] model_f16(input logic [47:0] x, input int fb);
      longint           sx;
      longint unsigned  mag, q, rem, half;
      int               e, qe, sh, ef;
      logic             sign;
      logic [15:0]      r;
      logic             ovf, unf;
      sign = x[47];
      sx   = longint'($signed(x));
      mag  = sign ? longint'(-sx) : longint'(sx);
      if (mag == 0) return 18'd0;
      e = -fb;
      for (int i = 0; i < 48; i++) if (mag[i]) e = i - fb;
      qe = ((e < -14) ? -14 : e) - 10;
      sh = qe + fb;
      if (sh > 0) begin
         q    = mag >> sh;
         rem  = mag - (q << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
      end else begin
         q = mag << (-sh);
      end
      if (q == 2048) begin
         q  = 1024;
         qe = qe + 1;
      end
      ovf = 1'b0;
      unf = 1'b0;
      if (q == 0) begin
         unf = 1'b1;
         r   = {sign, 15'h0000};
      end else if (q >= 1024) begin
         ef = qe + 25;
         if (ef >= 31) begin
            ovf = 1'b1;
            r   = {sign, 15'h7BFF};
         end else begin
            r = {sign, 5'(ef), 10'(q - 1024)};
         end
      end else begin
         r = {sign, 5'd0, 10'(q)};
      end
      return {ovf, unf, r};
   endfunction

   function automatic logic [47:0] rand_fixed();
      logic [63:0] r;
      r = {$urandom, $urandom};
      r = r >> $urandom_range(16, 63);
      if ($urandom_range(0, 1) == 1) r = 64'd0 - r;
      return r[47:0];
   endfunction

   task automatic send_single(input logic [47:0] x, output int lat,
                              output logic [17:0] o24, output logic [17:0] o26);
      @(negedge clk);
      ready_i  = 1'b1;
      valid_i  = 1'b1;
      fixed_in = x;
      @(posedge clk);
      @(negedge clk);
      valid_i  = 1'b0;
      fixed_in = '0;
      lat = 0;
      while (!vo24 && lat < 10) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      o24 = {ovf24, unf24, f24};
      o26 = {ovf26, unf26, f26};
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      valid_i  = 1'b0;
      ready_i  = 1'b0;
      fixed_in = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({vo24, f24, ovf24, unf24} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs24: got v=%0b f=%h o=%0b u=%0b, want all 0", vo24, f24, ovf24, unf24);
      end
      checks++;
      if ({vo26, f26, ovf26, unf26} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs26: got v=%0b f=%h o=%0b u=%0b, want all 0", vo26, f26, ovf26, unf26);
      end
      checks++;
      if (ready24 !== 1'b1 || ready26 !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %0b/%0b, want 1/1", ready24, ready26);
      end
      reset_n = 1'b1;
      ready_i = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (vo24 !== 1'b0 || vo26 !== 1'b0) begin
         errors++;
         $display("FAIL idle_valid: got %0b/%0b, want 0/0", vo24, vo26);
      end
   endtask

   task automatic test_directed();
      logic [47:0] vx [13];
      logic [17:0] ve [13];
      int          vf [13];
      int          lat;
      logic [17:0] o24, o26, got, other, want_other;
      vx[0]  = 48'h000001000000; ve[0]  = {2'b00, 16'h3C00}; vf[0]  = 24;
      vx[1]  = 48'hFFFFFD800000; ve[1]  = {2'b00, 16'hC100}; vf[1]  = 24;
      vx[2]  = 48'h000000000000; ve[2]  = {2'b00, 16'h0000}; vf[2]  = 24;
      vx[3]  = 48'h000001002000; ve[3]  = {2'b00, 16'h3C00}; vf[3]  = 24;
      vx[4]  = 48'h000001006000; ve[4]  = {2'b00, 16'h3C02}; vf[4]  = 24;
      vx[5]  = 48'h000000000001; ve[5]  = {2'b00, 16'h0001}; vf[5]  = 24;
      vx[6]  = 48'h0000000003FF; ve[6]  = {2'b00, 16'h03FF}; vf[6]  = 24;
      vx[7]  = 48'h00FFF0000000; ve[7]  = {2'b10, 16'h7BFF}; vf[7]  = 24;
      vx[8]  = 48'h7FFFFFFFFFFF; ve[8]  = {2'b10, 16'h7BFF}; vf[8]  = 24;
      vx[9]  = 48'h800000000000; ve[9]  = {2'b10, 16'hFBFF}; vf[9]  = 24;
      vx[10] = 48'h000000000001; ve[10] = {2'b01, 16'h0000}; vf[10] = 26;
      vx[11] = 48'hFFFFFFFFFFFE; ve[11] = {2'b01, 16'h8000}; vf[11] = 26;
      vx[12] = 48'h000000000FFE; ve[12] = {2'b00, 16'h0400}; vf[12] = 26;
      for (int i = 0; i < 13; i++) begin
         send_single(vx[i], lat, o24, o26);
         got        = (vf[i] == 24) ? o24 : o26;
         other      = (vf[i] == 24) ? o26 : o24;
         want_other = model_f16(vx[i], (vf[i] == 24) ? 26 : 24);
         checks++;
         if (lat != 3) begin
            errors++;
            $display("FAIL latency[%0d]: got %0d edges, want 3", i, lat);
         end
         checks++;
         if (got !== ve[i]) begin
            errors++;
            $display("FAIL directed[%0d] x=%h fb=%0d: got ovf/unf/f=%h, want %h", i, vx[i], vf[i], got, ve[i]);
         end
         checks++;
         if (other !== want_other) begin
            errors++;
            $display("FAIL directed_alt[%0d] x=%h: got %h, want %h", i, vx[i], other, want_other);
         end
      end
   endtask

   // Streams n random inputs; mode 0 stalls ready_i for cycles 4..6, mode 1 randomises
   // both ready_i and valid_i.
   task automatic run_stream(input int n, input bit rand_mode, input string tag);
      logic [47:0] xs [$];
      logic [17:0] q24 [$];
      logic [17:0] q26 [$];
      logic [17:0] held24, exp24, exp26;
      bit          held;
      int          sent, got;
      sent = 0;
      got  = 0;
      held = 1'b0;
      held24 = '0;
      for (int i = 0; i < n; i++) xs.push_back(rand_fixed());
      for (int cyc = 0; cyc < 2000 && got < n; cyc++) begin
         @(negedge clk);
         if (held) begin
            checks++;
            if (vo24 !== 1'b1 || {ovf24, unf24, f24} !== held24) begin
               errors++;
               $display("FAIL %s stall_hold: got v=%0b %h, want v=1 %h", tag, vo24, {ovf24, unf24, f24}, held24);
            end
         end
         ready_i = rand_mode ? ($urandom_range(0, 3) != 0) : !(cyc >= 4 && cyc <= 6);
         if (sent < n && (!rand_mode || $urandom_range(0, 3) != 0)) begin
            valid_i  = 1'b1;
            fixed_in = xs[sent];
         end else begin
            valid_i  = 1'b0;
            fixed_in = '0;
         end
         #1;
         checks++;
         if (ready24 !== !(vo24 && !ready_i) || ready26 !== ready24 || vo26 !== vo24) begin
            errors++;
            $display("FAIL %s ready_o: got %0b/%0b (v=%0b/%0b ready_i=%0b), want %0b", tag, ready24, ready26, vo24, vo26, ready_i, !(vo24 && !ready_i));
         end
         if (vo24 === 1'b1 && ready_i) begin
            checks++;
            if (q24.size() == 0) begin
               errors++;
               $display("FAIL %s extra_output: got %h, want none", tag, f24);
            end else begin
               exp24 = q24.pop_front();
               exp26 = q26.pop_front();
               if ({ovf24, unf24, f24} !== exp24 || {ovf26, unf26, f26} !== exp26) begin
                  errors++;
                  $display("FAIL %s result[%0d]: got %h/%h, want %h/%h", tag, got, {ovf24, unf24, f24}, {ovf26, unf26, f26}, exp24, exp26);
               end
            end
            got++;
         end
         held   = (vo24 === 1'b1) && !ready_i;
         held24 = {ovf24, unf24, f24};
         if (valid_i && ready24) begin
            q24.push_back(model_f16(xs[sent], 24));
            q26.push_back(model_f16(xs[sent], 26));
            sent++;
         end
      end
      @(negedge clk);
      valid_i = 1'b0;
      ready_i = 1'b1;
      checks++;
      if (got != n || q24.size() != 0) begin
         errors++;
         $display("FAIL %s count: got %0d results (%0d pending), want %0d", tag, got, q24.size(), n);
      end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      run_stream(8, 1'b0, "b2b");
   endtask

   task automatic test_random_stream();
      run_stream(60, 1'b1, "rand");
   endtask

   task automatic test_reset_midstream();
      logic [47:0] x;
      int          lat;
      logic [17:0] o24, o26;
      ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         valid_i  = 1'b1;
         fixed_in = rand_fixed() | 48'h1;
      end
      @(negedge clk);
      valid_i  = 1'b0;
      fixed_in = '0;
      @(negedge clk);
      checks++;
      if (vo24 !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_valid: got %0b, want 1", vo24);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (vo24 !== 1'b0 || vo26 !== 1'b0 || f24 !== 16'h0000 || ready24 !== 1'b1) begin
         errors++;
         $display("FAIL rst_async: got v=%0b/%0b f=%h rdy=%0b, want 0/0 0000 1", vo24, vo26, f24, ready24);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (vo24 !== 1'b0 || vo26 !== 1'b0) begin
            errors++;
            $display("FAIL rst_stale[%0d]: got %0b/%0b, want 0/0", k, vo24, vo26);
         end
      end
      x = 48'hFFFFFD800000;
      send_single(x, lat, o24, o26);
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL rst_latency: got %0d, want 3", lat);
      end
      checks++;
      if (o24 !== model_f16(x, 24) || o26 !== model_f16(x, 26)) begin
         errors++;
         $display("FAIL rst_result: got %h/%h, want %h/%h", o24, o26, model_f16(x, 24), model_f16(x, 26));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random_stream();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
